hv_pwm_rtn_sched: RTL and testbench

Scheduler for the high-voltage-side PWM return channel. Several HV event sources share the one reused PWM channel: interrupt edges, watchdog heartbeats and status codes. This block latches their symbol requests, picks one by fixed priority, and hands it to the downstream symbol encoder over a valid/done handshake. It enforces an idle guard gap between symbols and aborts a symbol the encoder never completes. It sits between the HV event logic and the PWM/INTB symbol encoder.

---
 rtl/hv_pwm_rtn_sched.sv | 148 ++++++++++++++
 tb/tb_hv_pwm_rtn_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hv_pwm_rtn_sched.sv
// HV PWM return-channel scheduler: latches per-source symbol requests, grants by fixed priority,
// and drives a valid/done handshake to the symbol encoder with a guard gap and a done timeout.
// state | meaning
// IDLE  | waiting for enable and a pending request
// SEND  | symbol presented to the encoder, waiting for done or timeout
// GAP   | forced idle guard gap after a symbol ends
module hv_pwm_rtn_sched #(
    parameter  int REQ_NUM = 4,
    parameter  int SYM_W   = 2,
    parameter  int GAP_CYC = 8,
    parameter  int TMO_CYC = 1023,
    localparam int SRC_W   = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
    localparam int TMO_W   = $clog2(TMO_CYC + 1),
    localparam int GAP_W   = $clog2(GAP_CYC + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic [REQ_NUM-1:0]       i_req,
    input  logic [REQ_NUM*SYM_W-1:0] i_req_sym,
    output logic [REQ_NUM-1:0]       o_req_ack,
    output logic                     o_sym_vld,
    output logic [SYM_W-1:0]         o_sym,
    output logic [SRC_W-1:0]         o_sym_src,
    input  logic                     i_sym_done,
    output logic                     o_busy,
    output logic                     o_tmo_err,
    input  logic                     i_err_clr,
    output logic [7:0]               o_ovwr_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                        state;
    logic [REQ_NUM-1:0]            pend;
    logic [REQ_NUM-1:0][SYM_W-1:0] psym;
    logic [TMO_W-1:0]              tmo_cnt;
    logic [GAP_W-1:0]              gap_cnt;

    logic [SRC_W-1:0]   grant_idx;
    logic               grant;
    logic               done_hit;
    logic               tmo_hit;
    logic [REQ_NUM-1:0] pend_nxt;
    logic [8:0]         ovwr_add;
    logic [9:0]         ovwr_sum;
    logic [7:0]         ovwr_nxt;
    logic               busy_nxt;

    always_comb begin
        grant_idx = '0;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            if (pend[k]) grant_idx = SRC_W'(k);
        end
        grant    = (state == ST_IDLE) && i_en && (|pend);
        done_hit = (state == ST_SEND) && i_sym_done;
        tmo_hit  = (state == ST_SEND) && !i_sym_done && (tmo_cnt == TMO_W'(TMO_CYC - 1));

        // The granted entry is cleared first, so a same-cycle request re-arms it without counting as an overwrite.
        pend_nxt = pend;
        ovwr_add = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (grant && (grant_idx == SRC_W'(k))) pend_nxt[k] = 1'b0;
            if (i_req[k]) begin
                if (pend_nxt[k]) ovwr_add = ovwr_add + 9'd1;
                pend_nxt[k] = 1'b1;
            end
        end
        ovwr_sum = {2'b00, o_ovwr_cnt} + {1'b0, ovwr_add};
        ovwr_nxt = (ovwr_sum > 10'd255) ? 8'hFF : ovwr_sum[7:0];

        busy_nxt = 1'b0;
        case (state)
            ST_IDLE: busy_nxt = grant;
            ST_SEND: busy_nxt = 1'b1;
            ST_GAP:  busy_nxt = (gap_cnt != GAP_W'(GAP_CYC - 1));
            default: busy_nxt = 1'b0;
        endcase
        busy_nxt = busy_nxt | (|pend_nxt);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            pend       <= '0;
            psym       <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            o_req_ack  <= '0;
            o_sym_vld  <= 1'b0;
            o_sym      <= '0;
            o_sym_src  <= '0;
            o_busy     <= 1'b0;
            o_tmo_err  <= 1'b0;
            o_ovwr_cnt <= '0;
        end else begin
            pend       <= pend_nxt;
            o_ovwr_cnt <= ovwr_nxt;
            o_busy     <= busy_nxt;
            o_req_ack  <= '0;
            for (int k = 0; k < REQ_NUM; k++) begin
                if (i_req[k]) psym[k] <= i_req_sym[k*SYM_W +: SYM_W];
            end

            if (tmo_hit)        o_tmo_err <= 1'b1;
            else if (i_err_clr) o_tmo_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        o_sym     <= psym[grant_idx];
                        o_sym_src <= grant_idx;
                        o_sym_vld <= 1'b1;
                        tmo_cnt   <= '0;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (done_hit) begin
                        o_sym_vld            <= 1'b0;
                        o_req_ack[o_sym_src] <= 1'b1;
                        gap_cnt              <= '0;
                        state                <= ST_GAP;
                    end else if (tmo_hit) begin
                        o_sym_vld <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) state <= ST_IDLE;
                    else                                 gap_cnt <= gap_cnt + GAP_W'(1);
                end
                default: begin
                    o_sym_vld <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hv_pwm_rtn_sched.sv
// Bench for hv_pwm_rtn_sched: directed scenarios plus random traffic, all checked against
// a transaction-timing reference model (pending table, grant start/free times, sticky error).
module tb_hv_pwm_rtn_sched;
    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int GAP = 8;
    localparam int TMO = 16;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_en = 1'b0;
    logic [N-1:0] i_req = '0;
    logic [N*SW-1:0] i_req_sym = '0;
    logic         i_sym_done = 1'b0;
    logic         i_err_clr = 1'b0;
    logic [N-1:0] o_req_ack;
    logic         o_sym_vld;
    logic [SW-1:0] o_sym;
    logic [1:0]   o_sym_src;
    logic         o_busy;
    logic         o_tmo_err;
    logic [7:0]   o_ovwr_cnt;

    hv_pwm_rtn_sched #(.REQ_NUM(N), .SYM_W(SW), .GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_req(i_req), .i_req_sym(i_req_sym),
        .o_req_ack(o_req_ack), .o_sym_vld(o_sym_vld), .o_sym(o_sym), .o_sym_src(o_sym_src),
        .i_sym_done(i_sym_done), .o_busy(o_busy), .o_tmo_err(o_tmo_err), .i_err_clr(i_err_clr),
        .o_ovwr_cnt(o_ovwr_cnt)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;

    // Reference model: what the outputs should be in the current cycle.
    bit [N-1:0]  m_pend;
    logic [1:0]  m_psym [N];
    bit          m_active;
    int          m_src;
    logic [1:0]  m_sym;
    int          m_start;
    int          m_free;
    int          cyc;
    bit          m_err;
    int          m_ovwr;
    logic [N-1:0] m_ack;
    bit          m_busy;

    task automatic model_reset();
        m_pend = '0;
        for (int k = 0; k < N; k++) m_psym[k] = 2'b0;
        m_active = 0; m_src = 0; m_sym = 2'b0; m_start = 0; m_free = 0;
        cyc = 0; m_err = 0; m_ovwr = 0; m_ack = '0; m_busy = 0;
    endtask

    task automatic model_step();
        bit tmo;
        tmo = 0;
        m_ack = '0;
        if (m_active) begin
            if (i_sym_done) begin
                m_active = 0;
                m_ack[m_src] = 1'b1;
                m_free = cyc + 1 + GAP;
            end else if (cyc - m_start == TMO - 1) begin
                m_active = 0;
                m_err = 1;
                tmo = 1;
                m_free = cyc + 1 + GAP;
            end
        end else if (cyc >= m_free && i_en && (|m_pend)) begin
            for (int k = N - 1; k >= 0; k--) if (m_pend[k]) m_src = k;
            m_active = 1;
            m_sym = m_psym[m_src];
            m_start = cyc + 1;
            m_pend[m_src] = 1'b0;
        end
        if (i_err_clr && !tmo) m_err = 0;
        for (int k = 0; k < N; k++) begin
            if (i_req[k]) begin
                if (m_pend[k] && m_ovwr < 255) m_ovwr++;
                m_pend[k] = 1'b1;
                m_psym[k] = i_req_sym[k*SW +: SW];
            end
        end
        cyc++;
        m_busy = m_active || (cyc < m_free) || (|m_pend);
    endtask

    function automatic logic [18:0] obs_vec();
        return {o_sym_vld, o_sym_vld ? o_sym : 2'b0, o_sym_vld ? o_sym_src : 2'b0,
                o_req_ack, o_busy, o_tmo_err, o_ovwr_cnt};
    endfunction

    function automatic logic [18:0] exp_vec();
        return {m_active, m_active ? m_sym : 2'b0, m_active ? 2'(m_src) : 2'b0,
                m_ack, m_busy, m_err, 8'(m_ovwr)};
    endfunction

    task automatic tick(input logic [N-1:0] r, input logic [N*SW-1:0] s, input logic d, input logic c);
        i_req = r; i_req_sym = s; i_sym_done = d; i_err_clr = c;
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        i_req = '0; i_sym_done = 1'b0; i_err_clr = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        tests++;
        if (obs_vec() !== 19'd0) begin
            fails++; $display("FAIL reset_values got=%h exp=0", obs_vec());
        end
        i_rst_n = 1'b1;
        tick('0, '0, 1'b0, 1'b0);
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL reset_idle got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        i_en = 1'b1;
        tick(4'b0100, 8'b0011_0000, 1'b0, 1'b0);
        for (int t = 1; t <= 24; t++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL single_model cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
            if (t == 2) begin
                tests++;
                if (o_sym_vld !== 1'b1 || o_sym !== 2'd3 || o_sym_src !== 2'd2) begin
                    fails++; $display("FAIL single_grant got vld=%b sym=%0d src=%0d exp 1/3/2", o_sym_vld, o_sym, o_sym_src);
                end
            end
            if (t == 11) begin
                tests++;
                if (o_req_ack !== 4'b0100) begin
                    fails++; $display("FAIL single_ack got=%b exp=0100", o_req_ack);
                end
            end
            if (t == 19) begin
                tests++;
                if (o_sym_vld !== 1'b0) begin
                    fails++; $display("FAIL single_gap_guard got vld=%b exp 0", o_sym_vld);
                end
            end
            if (t == 20) begin
                tests++;
                if (o_sym_vld !== 1'b1 || o_sym_src !== 2'd0) begin
                    fails++; $display("FAIL single_next_grant got vld=%b src=%0d exp 1/0", o_sym_vld, o_sym_src);
                end
            end
            tick((t == 11) ? 4'b0001 : 4'b0000, '0, t == 10, 1'b0);
        end
    endtask

    task automatic test_priority();
        logic [N-1:0] acks [$];
        do_reset();
        i_en = 1'b1;
        tick(4'b1010, N*SW'($urandom), 1'b0, 1'b0);
        for (int t = 1; t <= 40; t++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL priority_model cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
            if (o_req_ack !== 4'b0000) acks.push_back(o_req_ack);
            tick('0, '0, m_active && (cyc - m_start == 2), 1'b0);
        end
        tests++;
        if (acks.size() != 2 || acks[0] !== 4'b0010 || acks[1] !== 4'b1000) begin
            fails++; $display("FAIL priority_order got n=%0d first=%b exp n=2 0010 then 1000",
                              acks.size(), (acks.size() > 0) ? acks[0] : 4'b0);
        end
    endtask

    task automatic test_overwrite();
        logic [N*SW-1:0] s;
        do_reset();
        i_en = 1'b1;
        tick(4'b0001, 8'b0000_0010, 1'b0, 1'b0);
        for (int t = 1; t <= 20; t++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL overwrite_model cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
            if (t == 5) begin
                tests++;
                if (o_ovwr_cnt !== 8'd1) begin
                    fails++; $display("FAIL overwrite_count got=%0d exp=1", o_ovwr_cnt);
                end
            end
            if (t == 16) begin
                tests++;
                if (o_sym_vld !== 1'b1 || o_sym !== 2'd2 || o_sym_src !== 2'd3) begin
                    fails++; $display("FAIL overwrite_sym got vld=%b sym=%0d src=%0d exp 1/2/3", o_sym_vld, o_sym, o_sym_src);
                end
            end
            s = (t == 2) ? 8'b0100_0000 : 8'b1000_0000;
            tick((t == 2 || t == 3) ? 4'b1000 : 4'b0000, s, t == 6 || t == 18, 1'b0);
        end
    endtask

    task automatic test_timeout();
        int vld_hi;
        bit ack_seen;
        vld_hi = 0; ack_seen = 0;
        do_reset();
        i_en = 1'b1;
        tick(4'b0100, 8'b0001_0000, 1'b0, 1'b0);
        for (int t = 1; t <= 65; t++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
            if (t <= 40) begin
                if (o_sym_vld === 1'b1) vld_hi++;
                if (o_req_ack !== 4'b0000) ack_seen = 1;
            end
            if (t == 30) begin
                tests++;
                if (o_tmo_err !== 1'b1) begin
                    fails++; $display("FAIL timeout_flag got=%b exp=1", o_tmo_err);
                end
            end
            if (t == 40) begin
                tests++;
                if (vld_hi != TMO || ack_seen || o_tmo_err !== 1'b0) begin
                    fails++; $display("FAIL timeout_window got vld_cycles=%0d ack=%b err=%b exp %0d/0/0", vld_hi, ack_seen, o_tmo_err, TMO);
                end
            end
            if (t == 59) begin
                tests++;
                if (o_req_ack !== 4'b0001 || o_tmo_err !== 1'b0) begin
                    fails++; $display("FAIL timeout_done_wins got ack=%b err=%b exp 0001/0", o_req_ack, o_tmo_err);
                end
            end
            tick((t == 41) ? 4'b0001 : 4'b0000, '0, t == 58, (t == 17) || (t == 30));
        end
    endtask

    task automatic test_enable();
        do_reset();
        i_en = 1'b0;
        tick(4'b0001, 8'b0000_0011, 1'b0, 1'b0);
        for (int t = 1; t <= 6; t++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL enable_model cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
            if (t == 6) begin
                tests++;
                if (o_sym_vld !== 1'b0 || o_busy !== 1'b1) begin
                    fails++; $display("FAIL enable_gated got vld=%b busy=%b exp 0/1", o_sym_vld, o_busy);
                end
                i_en = 1'b1;
            end
            tick('0, '0, 1'b0, 1'b0);
        end
        tests++;
        if (o_sym_vld !== 1'b1 || o_sym !== 2'd3 || obs_vec() !== exp_vec()) begin
            fails++; $display("FAIL enable_release got vld=%b sym=%0d exp 1/3", o_sym_vld, o_sym);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_en = 1'b1;
        tick(4'b0010, 8'b0000_1100, 1'b0, 1'b0);
        tick(4'b1000, 8'b1100_0000, 1'b0, 1'b0);
        tick('0, '0, 1'b0, 1'b0);
        tests++;
        if (o_sym_vld !== 1'b1 || o_busy !== 1'b1) begin
            fails++; $display("FAIL rstmid_send got vld=%b busy=%b exp 1/1", o_sym_vld, o_busy);
        end
        #2;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (obs_vec() !== 19'd0) begin
            fails++; $display("FAIL rstmid_async got=%h exp=0", obs_vec());
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int t = 0; t < 15; t++) begin
            tick('0, '0, 1'(($urandom % 2) == 0), 1'b0);
            tests++;
            if (o_req_ack !== 4'b0000 || o_sym_vld !== 1'b0 || obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL rstmid_after cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        do_reset();
        for (int t = 0; t < 800; t++) begin
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL random_model cyc=%0d got=%h exp=%h", t, obs_vec(), exp_vec());
            end
            i_en = (($urandom % 10) != 0);
            for (int k = 0; k < N; k++) r[k] = (($urandom % 12) == 0);
            tick(r, N*SW'($urandom), 1'(($urandom % 6) == 0), 1'(($urandom % 20) == 0));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_overwrite();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
